// File: rtl/id_ex_skid_pkg.sv
// Shared encodings and default field widths for the ID->EX boundary.
package id_ex_skid_pkg;

    // Default field widths of the MIPS32 decode bundle.
    localparam int unsigned AluopWDefault  = 8;
    localparam int unsigned AluselWDefault = 3;
    localparam int unsigned DataWDefault   = 32;
    localparam int unsigned AddrWDefault   = 5;
    localparam int unsigned SideWDefault   = 32;
    localparam int unsigned CntWDefault    = 16;

    // NOP encoding driven on the EX side whenever no valid bundle is held.
    localparam logic [7:0]  EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP = 3'b000;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr  = 5'b00000;

    // Width of one flattened bundle: {aluop, alusel, reg1, reg2, waddr, wr_en, side}.
    function automatic int unsigned bundle_width(
        input int unsigned aluop_w,
        input int unsigned alusel_w,
        input int unsigned data_w,
        input int unsigned addr_w,
        input int unsigned side_w
    );
        return aluop_w + alusel_w + 2 * data_w + addr_w + 1 + side_w;
    endfunction

endpackage

// File: rtl/id_ex_skid_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module id_ex_skid_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on reset, otherwise step up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (rst) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_ex_skid.sv
// ID->EX pipeline boundary: main register plus one-entry skid buffer, registered
// ready, synchronous flush, NOP-gated outputs and a saturating bubble counter.
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int unsigned ALUOP_W  = AluopWDefault,
    parameter int unsigned ALUSEL_W = AluselWDefault,
    parameter int unsigned DATA_W   = DataWDefault,
    parameter int unsigned ADDR_W   = AddrWDefault,
    parameter int unsigned SIDE_W   = SideWDefault,
    parameter int unsigned CNT_W    = CntWDefault
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [ADDR_W-1:0]   id_waddr,
    input  logic                id_wr_en,
    input  logic [SIDE_W-1:0]   id_side,

    input  logic                flush,

    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [ADDR_W-1:0]   ex_waddr,
    output logic                ex_wr_en,
    output logic [SIDE_W-1:0]   ex_side,

    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam int unsigned BundleW =
        bundle_width(ALUOP_W, ALUSEL_W, DATA_W, ADDR_W, SIDE_W);

    // Field offsets inside a flattened bundle (side occupies the LSBs).
    localparam int unsigned SideLsb   = 0;
    localparam int unsigned WrEnLsb   = SideLsb + SIDE_W;
    localparam int unsigned WaddrLsb  = WrEnLsb + 1;
    localparam int unsigned Reg2Lsb   = WaddrLsb + ADDR_W;
    localparam int unsigned Reg1Lsb   = Reg2Lsb + DATA_W;
    localparam int unsigned AluselLsb = Reg1Lsb + DATA_W;
    localparam int unsigned AluopLsb  = AluselLsb + ALUSEL_W;

    localparam logic [BundleW-1:0] NopBundle = {
        ALUOP_W'(EXE_NOP_OP),
        ALUSEL_W'(EXE_RES_NOP),
        DATA_W'(ZeroWord),
        DATA_W'(ZeroWord),
        ADDR_W'(NOPRegAddr),
        1'b0,
        SIDE_W'(ZeroWord)
    };

    logic [BundleW-1:0] in_bundle;
    logic [BundleW-1:0] m_q, m_d;
    logic [BundleW-1:0] s_q, s_d;
    logic               m_valid_q, m_valid_d;
    logic               s_valid_q, s_valid_d;
    logic               accept;
    logic               drain;

    assign in_bundle = {id_aluop, id_alusel, id_reg1, id_reg2, id_waddr, id_wr_en, id_side};

    // Ready comes straight from a flop, so ex_ready never reaches id_ready combinationally.
    assign id_ready = ~s_valid_q;
    assign accept   = id_valid & id_ready;
    assign drain    = m_valid_q & ex_ready;

    // Next state of the main/skid pair. M is written with the NOP bundle whenever it
    // goes empty, so the EX outputs need no valid-gating mux.
    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (rst || flush) begin
            m_d       = NopBundle;
            s_d       = NopBundle;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || drain) begin
            if (s_valid_q) begin
                // Skid entry is older than anything arriving now.
                m_d       = s_q;
                m_valid_d = 1'b1;
                if (accept) begin
                    s_d       = in_bundle;
                    s_valid_d = 1'b1;
                end else begin
                    s_d       = NopBundle;
                    s_valid_d = 1'b0;
                end
            end else if (accept) begin
                m_d       = in_bundle;
                m_valid_d = 1'b1;
            end else begin
                m_d       = NopBundle;
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            // M stalled: park the incoming bundle in the skid slot.
            s_d       = in_bundle;
            s_valid_d = 1'b1;
        end
    end

    // Main and skid registers.
    always_ff @(posedge clk) begin
        m_q       <= m_d;
        s_q       <= s_d;
        m_valid_q <= m_valid_d;
        s_valid_q <= s_valid_d;
    end

    assign ex_valid  = m_valid_q;
    assign ex_aluop  = m_q[AluopLsb  +: ALUOP_W];
    assign ex_alusel = m_q[AluselLsb +: ALUSEL_W];
    assign ex_reg1   = m_q[Reg1Lsb   +: DATA_W];
    assign ex_reg2   = m_q[Reg2Lsb   +: DATA_W];
    assign ex_waddr  = m_q[WaddrLsb  +: ADDR_W];
    assign ex_wr_en  = m_q[WrEnLsb];
    assign ex_side   = m_q[SideLsb   +: SIDE_W];

    id_ex_skid_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~m_valid_q),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_skid.sv
// Self-checking bench for id_ex_skid: the reference model treats the boundary as a
// two-deep FIFO with ready = (occupancy < 2) and a saturating idle-cycle counter.
module tb_id_ex_skid;

    localparam int unsigned CntW = 4;
    localparam int unsigned BW   = 8 + 3 + 32 + 32 + 5 + 1 + 32;
    localparam int unsigned AllW = 2 + BW + CntW;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [7:0]  id_aluop;
    logic [2:0]  id_alusel;
    logic [31:0] id_reg1;
    logic [31:0] id_reg2;
    logic [4:0]  id_waddr;
    logic        id_wr_en;
    logic [31:0] id_side;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic [4:0]  ex_waddr;
    logic        ex_wr_en;
    logic [31:0] ex_side;
    logic [CntW-1:0] bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [BW-1:0] mq[$];
    int unsigned   mcnt = 0;

    id_ex_skid #(
        .CNT_W (CntW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_aluop   (id_aluop),
        .id_alusel  (id_alusel),
        .id_reg1    (id_reg1),
        .id_reg2    (id_reg2),
        .id_waddr   (id_waddr),
        .id_wr_en   (id_wr_en),
        .id_side    (id_side),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_aluop   (ex_aluop),
        .ex_alusel  (ex_alusel),
        .ex_reg1    (ex_reg1),
        .ex_reg2    (ex_reg2),
        .ex_waddr   (ex_waddr),
        .ex_wr_en   (ex_wr_en),
        .ex_side    (ex_side),
        .bubble_cnt (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [BW-1:0] in_vec();
        return {id_aluop, id_alusel, id_reg1, id_reg2, id_waddr, id_wr_en, id_side};
    endfunction

    function automatic logic [AllW-1:0] dut_all();
        return {id_ready, ex_valid,
                ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_waddr, ex_wr_en, ex_side,
                bubble_cnt};
    endfunction

    function automatic logic [AllW-1:0] exp_all();
        logic [BW-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        return {(mq.size() < 2), (mq.size() > 0), head, CntW'(mcnt)};
    endfunction

    function automatic bit model_ready();
        return mq.size() < 2;
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge, then
    // return at the falling edge where outputs are sampled.
    task automatic cycle();
        bit acc;
        bit drn;
        @(posedge clk);
        acc = id_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && ex_ready;
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (mq.size() == 0) mcnt = (mcnt >= (1 << CntW) - 1) ? mcnt : mcnt + 1;
            if (flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(in_vec());
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_fields();
        id_aluop  = 8'($urandom);
        id_alusel = 3'($urandom);
        id_reg1   = $urandom;
        id_reg2   = $urandom;
        id_waddr  = 5'($urandom);
        id_wr_en  = 1'($urandom);
        id_side   = $urandom;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        id_valid = 1'b1;
        rand_fields();
        id_aluop = 8'h21;
        id_wr_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (ex_valid !== 1'b0 || ex_aluop !== 8'h00 || ex_wr_en !== 1'b0 ||
                id_ready !== 1'b1 || bubble_cnt !== '0) begin
                n_err++;
                $display("FAIL reset: valid=%b aluop=%h wr_en=%b ready=%b cnt=%0d, want 0 00 0 1 0",
                         ex_valid, ex_aluop, ex_wr_en, id_ready, bubble_cnt);
            end
            n_cmp++;
            if (dut_all() !== exp_all()) begin
                n_err++;
                $display("FAIL reset_model: got %h want %h", dut_all(), exp_all());
            end
        end
        rst      = 1'b0;
        id_valid = 1'b0;
        ex_ready = 1'b1;
        cycle();
    endtask

    task automatic test_streaming();
        ex_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            id_valid = 1'b1;
            rand_fields();
            id_reg1 = k;
            cycle();
            n_cmp++;
            if (ex_valid !== 1'b1 || ex_reg1 !== 32'(k)) begin
                n_err++;
                $display("FAIL stream_%0d: valid=%b reg1=%0d, want 1 %0d", k, ex_valid, ex_reg1, k);
            end
            n_cmp++;
            if (dut_all() !== exp_all()) begin
                n_err++;
                $display("FAIL stream_model: got %h want %h", dut_all(), exp_all());
            end
        end
        id_valid = 1'b0;
        cycle();
        n_cmp++;
        if (ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: valid=%b, want 0", ex_valid);
        end
    endtask

    task automatic test_skid_fill();
        int          nxt_off = 1;
        int          nxt_con = 1;
        logic [31:0] prev_reg1 = '0;
        bit          prev_stall = 1'b0;
        id_reg2   = 32'h0;
        id_aluop  = 8'h5a;
        id_alusel = 3'd2;
        id_waddr  = 5'd9;
        id_wr_en  = 1'b1;
        id_side   = 32'hcafe_0000;
        for (int step = 0; step < 30; step++) begin
            bit acc;
            ex_ready = !(step inside {6, 7, 8});
            id_valid = (nxt_off <= 12);
            id_reg1  = nxt_off;
            acc      = id_valid && model_ready();
            if (ex_valid && ex_ready) begin
                n_cmp++;
                if (ex_reg1 !== 32'(nxt_con)) begin
                    n_err++;
                    $display("FAIL skid_order: reg1=%0d want %0d", ex_reg1, nxt_con);
                end
                nxt_con++;
            end
            cycle();
            if (acc) nxt_off++;
            if (prev_stall) begin
                n_cmp++;
                if (ex_reg1 !== prev_reg1 || ex_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL skid_hold: reg1=%0d valid=%b want %0d 1", ex_reg1, ex_valid, prev_reg1);
                end
            end
            if (step == 6) begin
                n_cmp++;
                if (id_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL skid_ready_fall: ready=%b want 0", id_ready);
                end
            end
            prev_stall = ex_valid && !(step + 1 inside {9, 10, 11, 12}) && (step + 1 inside {6, 7, 8});
            prev_reg1  = ex_reg1;
            n_cmp++;
            if (dut_all() !== exp_all()) begin
                n_err++;
                $display("FAIL skid_model: got %h want %h", dut_all(), exp_all());
            end
        end
        n_cmp++;
        if (nxt_con != 13) begin
            n_err++;
            $display("FAIL skid_count: consumed up to %0d want 13", nxt_con - 1);
        end
    endtask

    task automatic flush_monitor(input string name);
        id_valid = 1'b0;
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++;
            if (ex_wr_en && (ex_waddr inside {5'd3, 5'd4, 5'd7})) begin
                n_err++;
                $display("FAIL %s_leak: waddr=%0d wr_en=%b want no write", name, ex_waddr, ex_wr_en);
            end
        end
    endtask

    task automatic test_flush();
        // Case 1: M and S both full, third bundle offered while flushing.
        ex_ready = 1'b0;
        id_valid = 1'b1;
        rand_fields();
        id_wr_en = 1'b1;
        id_waddr = 5'd3;
        cycle();
        id_waddr = 5'd4;
        cycle();
        n_cmp++;
        if (id_ready !== 1'b0 || ex_waddr !== 5'd3) begin
            n_err++;
            $display("FAIL flush_fill: ready=%b waddr=%0d want 0 3", id_ready, ex_waddr);
        end
        id_waddr = 5'd7;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_wr_en !== 1'b0 || id_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full: valid=%b wr_en=%b ready=%b want 0 0 1",
                     ex_valid, ex_wr_en, id_ready);
        end
        n_cmp++;
        if (dut_all() !== exp_all()) begin
            n_err++;
            $display("FAIL flush_model: got %h want %h", dut_all(), exp_all());
        end
        flush_monitor("flush_full");
        // Case 2: bundle accepted in the flush cycle must be dropped.
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_waddr = 5'd3;
        cycle();
        id_waddr = 5'd7;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_wr_en !== 1'b0 || id_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_accept: valid=%b wr_en=%b ready=%b want 0 0 1",
                     ex_valid, ex_wr_en, id_ready);
        end
        flush_monitor("flush_accept");
    endtask

    task automatic test_bubble_saturation();
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        id_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            n_cmp++;
            if (dut_all() !== exp_all()) begin
                n_err++;
                $display("FAIL bubble_model_%0d: got %h want %h", i, dut_all(), exp_all());
            end
        end
        n_cmp++;
        if (bubble_cnt !== 4'd15) begin
            n_err++;
            $display("FAIL bubble_sat: cnt=%0d want 15", bubble_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        ex_ready = 1'b0;
        id_valid = 1'b1;
        rand_fields();
        id_reg1 = 32'd55;
        cycle();
        id_reg1 = 32'd66;
        cycle();
        n_cmp++;
        if (id_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rststall_fill: ready=%b want 0", id_ready);
        end
        rst     = 1'b1;
        id_reg1 = 32'd77;
        cycle();
        rst      = 1'b0;
        id_valid = 1'b0;
        n_cmp++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b1 || bubble_cnt !== '0) begin
            n_err++;
            $display("FAIL rststall: valid=%b ready=%b cnt=%0d want 0 1 0",
                     ex_valid, id_ready, bubble_cnt);
        end
        ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (ex_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rststall_emerge: valid=%b reg1=%0d want no bundle", ex_valid, ex_reg1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(3) != 0);
            ex_ready = ($urandom_range(2) != 0);
            flush    = ($urandom_range(31) == 0);
            rst      = ($urandom_range(96) == 0);
            rand_fields();
            cycle();
            n_cmp++;
            if (dut_all() !== exp_all()) begin
                n_err++;
                $display("FAIL random_%0d: got %h want %h", i, dut_all(), exp_all());
            end
        end
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        id_valid = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        rand_fields();
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush();
        test_bubble_saturation();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_skid.md
# id_ex_skid

Parametrised ID→EX pipeline boundary register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating bubble counter. It sits between the decode stage and the execute stage of the MIPS32 core. It lets either stage stall the other without combinational ready paths, and lets the branch/exception controller squash in-flight decode results. Any cycle without valid data presents the NOP encoding on the EX side.

## Interface
- ALUOP_W, 8: ALU operation field width
- ALUSEL_W, 3: ALU result-select field width
- DATA_W, 32: source operand width
- ADDR_W, 5: register file address width
- SIDE_W, 32: opaque sideband payload (instruction word, link address), passed through unmodified
- CNT_W, 16: bubble counter width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode offers a bundle
- id_ready  out  1  boundary can accept; registered (no combinational path from ex_ready)
- id_aluop, id_alusel, id_reg1, id_reg2, id_waddr, id_wr_en, id_side  in  ALUOP_W/ALUSEL_W/DATA_W/DATA_W/ADDR_W/1/SIDE_W  decode bundle
- flush  in  1  squash all held and incoming bundles
- ex_valid  out  1  EX-side bundle valid
- ex_ready  in  1  execute consumes the bundle this cycle
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_waddr, ex_wr_en, ex_side  out  same widths  EX-side bundle
- bubble_cnt  out  CNT_W  saturating count of cycles with ex_valid=0

## Operation
- Storage: main register M (drives ex_*) and skid register S, each with its own valid bit.
- Accept: id_valid && id_ready. Drain: ex_valid && ex_ready.
- Each cycle, with no flush:
  - If M is empty or draining, M loads S when S is valid (S then empties). Otherwise M loads the accepted input, or becomes empty if no input was accepted.
  - If M is full and not draining and an input is accepted, the input goes to S.
  - If M is draining, S is valid and an input is accepted, the input goes to S and the old S moves to M.
- id_ready is registered as !S_valid. With S empty, one input can always be absorbed, so no data is lost while backpressure propagates.
- Flush takes priority over every other event. M_valid and S_valid clear on the next edge, and any input accepted in the same cycle is discarded. id_ready returns high on the next cycle.
- NOP encoding, driven whenever ex_valid=0 and during reset: ex_aluop=0, ex_alusel=0, ex_reg1=ex_reg2=0, ex_waddr=0, ex_wr_en=0, ex_side=0. The gating is registered and is not an output mux on the valid bit. A squashed bundle therefore never asserts ex_wr_en.
- bubble_cnt increments by 1 every cycle in which ex_valid=0 and rst=0. It holds at 2^CNT_W−1 and does not wrap.

## Timing
- Reset values: ex_valid=0, all ex_* at NOP, id_ready=1, bubble_cnt=0, S_valid=0.
- Reset in mid-operation discards both entries on that edge, with the same values as above.
- Latency: an accepted bundle appears on ex_* on the next edge when M is empty or draining. It takes one extra cycle per stalled cycle when the bundle went into S.
- Full throughput: with ex_ready held at 1 the block streams one bundle per cycle.
- Backpressure: ex_ready falling for one cycle while streaming fills S. id_ready then falls on the following cycle.
- Recovery: id_ready returns to 1 one cycle after S empties.
- Output hold: ex_* are stable while ex_valid=1 and ex_ready=0.

## Structure
- Shared package/defines: EXE_NOP_OP, EXE_RES_NOP, ZeroWord, NOPRegAddr, and the default field widths.
- Bundle type: a packed bundle struct or concatenation helper, so that M and S are each one vector of width ALUOP_W+ALUSEL_W+2·DATA_W+ADDR_W+1+SIDE_W.
- One sub-module is natural: sat_counter (CNT_W, inc, rst) for bubble_cnt.

## Test plan
- Reset: assert rst for 2 cycles with id_valid=1 and id_aluop=8'h21. Required response: ex_valid=0, ex_aluop=0, ex_wr_en=0, id_ready=1, bubble_cnt=0.
- Streaming: feed bundles reg1=1..8 back-to-back with ex_ready=1. Required response: ex_reg1 shows 1..8 on consecutive cycles, one cycle late; no drops and no duplicates.
- Skid fill:
  - While streaming, drop ex_ready for 3 cycles. Required response: id_ready falls one cycle later and ex_* hold steady.
  - Restore ex_ready. Required response: the sequence continues with no gaps, and the skid bundle follows immediately.
- Flush: with M and S both full (waddr=5'd3 and 5'd4) and an input with waddr=5'd7 offered, pulse flush. Required response: next cycle ex_valid=0 and ex_wr_en=0; waddr 3, 4 and 7 never reach EX with wr_en=1.
- Bubble counter saturation: with CNT_W=4, hold id_valid=0 for 20 cycles. Required response: bubble_cnt reaches 15 and stays at 15.
- Reset mid-stall: with S full, assert rst for one cycle. Required response: the next cycle shows ex_valid=0, id_ready=1, bubble_cnt=0, and the held bundles never emerge.
